trap_sequencer: RTL and testbench

//  Sequences exception/interrupt entry and return for the 16-bit core. Latches fault and

---
 rtl/trap_sequencer_pkg.sv | 31 +++
 rtl/trap_sequencer_prio_enc.sv | 28 ++
 rtl/trap_sequencer.sv | 128 ++++++++++++
 tb/tb_trap_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_sequencer_pkg.sv
// Shared types and default handler vectors for the trap sequencer.
package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ENTER,
    ST_HANDLER,
    ST_RETURN
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE  = 3'd0,
    CAUSE_SPART = 3'd1,
    CAUSE_IPC   = 3'd2,
    CAUSE_IMEM  = 3'd3,
    CAUSE_BADI  = 3'd4
  } cause_t;

  // Bit positions in the pending vector; higher bit wins arbitration.
  localparam int PEND_SPART = 3;
  localparam int PEND_IPC   = 2;
  localparam int PEND_IMEM  = 1;
  localparam int PEND_BADI  = 0;

  localparam logic [15:0] DEF_SPART_VEC = 16'h0030;
  localparam logic [15:0] DEF_IPC_VEC   = 16'h0000;
  localparam logic [15:0] DEF_IMEM_VEC  = 16'h0100;
  localparam logic [15:0] DEF_BADI_VEC  = 16'h0060;

endpackage

// File: rtl/trap_sequencer_prio_enc.sv
// Fixed-priority pick of one pending trap: one-hot winner plus its cause code.
module trap_prio_enc
  import trap_sequencer_pkg::*;
(
  input  logic [3:0] pending,
  output logic [3:0] winner,
  output cause_t     code
);

  always_comb begin
    winner = 4'b0000;
    code   = CAUSE_NONE;
    if (pending[PEND_SPART]) begin
      winner[PEND_SPART] = 1'b1;
      code               = CAUSE_SPART;
    end else if (pending[PEND_IPC]) begin
      winner[PEND_IPC] = 1'b1;
      code             = CAUSE_IPC;
    end else if (pending[PEND_IMEM]) begin
      winner[PEND_IMEM] = 1'b1;
      code              = CAUSE_IMEM;
    end else if (pending[PEND_BADI]) begin
      winner[PEND_BADI] = 1'b1;
      code              = CAUSE_BADI;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: latches causes, drains the pipe, redirects fetch to
// the handler vector, and on eret redirects back to the saved PC dropping privilege.
//
// state   | meaning
// IDLE    | no trap in service; take highest pending cause
// DRAIN   | waiting for pipe_idle or the drain timeout
// ENTER   | one-cycle redirect to the handler vector
// HANDLER | handler running; new causes only accumulate
// RETURN  | one-cycle redirect to epc with privilege drop
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [15:0] SPART_VEC = DEF_SPART_VEC,
  parameter logic [15:0] IPC_VEC   = DEF_IPC_VEC,
  parameter logic [15:0] IMEM_VEC  = DEF_IMEM_VEC,
  parameter logic [15:0] BADI_VEC  = DEF_BADI_VEC,
  parameter int          DRAIN_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bad_instr,
  input  logic        illegal_pc,
  input  logic        illegal_mem,
  input  logic        spart_rcv,
  input  logic [1:0]  mode,
  input  logic [15:0] cur_pc,
  input  logic        pipe_idle,
  input  logic        eret,
  output logic        redirect,
  output logic [15:0] redirect_pc,
  output logic [1:0]  mode_set,
  output logic [15:0] epc,
  output logic [2:0]  cause,
  output logic        drain_tmo
);

  localparam int CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_MAX - 1);

  state_t        state;
  cause_t        cause_q;
  cause_t        win_code;
  logic [CW-1:0] cnt;
  logic [3:0]    pending;
  logic [3:0]    set_bits;
  logic [3:0]    winner;
  logic [3:0]    take;
  logic [15:0]   vec_sel;
  logic          unused_mode;

  // Receive interrupts are masked while privileged.
  assign set_bits    = {spart_rcv & ~mode[1], illegal_pc, illegal_mem, bad_instr};
  assign take        = (state == ST_IDLE) ? winner : 4'b0000;
  assign cause       = cause_q;
  assign unused_mode = mode[0];

  trap_prio_enc u_prio (
    .pending (pending),
    .winner  (winner),
    .code    (win_code)
  );

  always_comb begin
    vec_sel = 16'h0000;
    case (cause_q)
      CAUSE_SPART: vec_sel = SPART_VEC;
      CAUSE_IPC:   vec_sel = IPC_VEC;
      CAUSE_IMEM:  vec_sel = IMEM_VEC;
      CAUSE_BADI:  vec_sel = BADI_VEC;
      default:     vec_sel = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      pending     <= 4'b0000;
      cnt         <= '0;
      cause_q     <= CAUSE_NONE;
      epc         <= 16'h0000;
      redirect    <= 1'b0;
      redirect_pc <= 16'h0000;
      mode_set    <= 2'b00;
      drain_tmo   <= 1'b0;
    end else begin
      redirect    <= 1'b0;
      redirect_pc <= 16'h0000;
      mode_set    <= 2'b00;
      // A cause re-asserted in the cycle it is taken stays pending.
      pending     <= (pending & ~take) | set_bits;
      case (state)
        ST_IDLE: begin
          if (|pending) begin
            epc     <= cur_pc;
            cause_q <= win_code;
            cnt     <= '0;
            state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pipe_idle || cnt == CNT_LAST) begin
            if (!pipe_idle) drain_tmo <= 1'b1;
            redirect    <= 1'b1;
            redirect_pc <= vec_sel;
            state       <= ST_ENTER;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_ENTER: state <= ST_HANDLER;
        ST_HANDLER: begin
          if (eret) begin
            redirect    <= 1'b1;
            redirect_pc <= epc;
            mode_set    <= 2'b11;
            state       <= ST_RETURN;
          end
        end
        ST_RETURN: begin
          cause_q <= CAUSE_NONE;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios with literal expectations, then random
// traffic compared every cycle against a cause-list model of trap entry/return.
module tb_trap_sequencer;

  localparam int DRAIN_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        bad_instr, illegal_pc, illegal_mem, spart_rcv, pipe_idle, eret;
  logic [1:0]  mode;
  logic [15:0] cur_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [1:0]  mode_set;
  logic [15:0] epc;
  logic [2:0]  cause;
  logic        drain_tmo;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int redir_cnt = 0;

  trap_sequencer #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk         (clk),
    .rst         (rst),
    .bad_instr   (bad_instr),
    .illegal_pc  (illegal_pc),
    .illegal_mem (illegal_mem),
    .spart_rcv   (spart_rcv),
    .mode        (mode),
    .cur_pc      (cur_pc),
    .pipe_idle   (pipe_idle),
    .eret        (eret),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mode_set    (mode_set),
    .epc         (epc),
    .cause       (cause),
    .drain_tmo   (drain_tmo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Causes are numbered 1..4 in priority order (1 = highest), so the winner is simply
  // the lowest-numbered pending cause. The trap walk is a list of phases.
  localparam int WAITING = 0, DRAINING = 1, ENTERING = 2, IN_HANDLER = 3, RETURNING = 4;

  function automatic logic [15:0] handler_addr(input int c);
    case (c)
      1: return 16'h0030;
      2: return 16'h0000;
      3: return 16'h0100;
      4: return 16'h0060;
      default: return 16'h0000;
    endcase
  endfunction

  bit [4:1]    m_pend;
  int          m_phase;
  int          m_waited;
  int          m_cause;
  logic [15:0] m_epc;
  logic        m_tmo;
  logic        m_redirect;
  logic [15:0] m_rpc;
  logic [1:0]  m_mode_set;

  always @(posedge clk or posedge rst) begin : model
    bit [4:1]    raised;
    bit [4:1]    pend_n;
    int          taken, ph, waited, cs;
    logic [15:0] ep, rpc;
    logic        tmo, rd;
    logic [1:0]  ms;
    if (rst) begin
      m_pend <= '0; m_phase <= WAITING; m_waited <= 0; m_cause <= 0; m_epc <= '0;
      m_tmo <= 1'b0; m_redirect <= 1'b0; m_rpc <= '0; m_mode_set <= 2'b00;
    end else begin
      raised = {bad_instr, illegal_mem, illegal_pc, spart_rcv & ~mode[1]};
      taken = 0; ph = m_phase; waited = m_waited; cs = m_cause; ep = m_epc; tmo = m_tmo;
      rd = 1'b0; rpc = 16'h0; ms = 2'b00;
      case (m_phase)
        WAITING: begin
          for (int c = 4; c >= 1; c--) if (m_pend[c]) taken = c;
          if (taken != 0) begin
            cs = taken; ep = cur_pc; waited = 0; ph = DRAINING;
          end
        end
        DRAINING: begin
          if (pipe_idle || waited == DRAIN_MAX - 1) begin
            if (!pipe_idle) tmo = 1'b1;
            rd = 1'b1; rpc = handler_addr(m_cause); ph = ENTERING;
          end else waited++;
        end
        ENTERING: ph = IN_HANDLER;
        IN_HANDLER: if (eret) begin
          rd = 1'b1; rpc = m_epc; ms = 2'b11; ph = RETURNING;
        end
        default: begin cs = 0; ph = WAITING; end
      endcase
      for (int c = 1; c <= 4; c++) pend_n[c] = (m_pend[c] && c != taken) || raised[c];
      m_pend <= pend_n; m_phase <= ph; m_waited <= waited; m_cause <= cs; m_epc <= ep;
      m_tmo <= tmo; m_redirect <= rd; m_rpc <= rpc; m_mode_set <= ms;
    end
  end

  always @(negedge clk) begin
    chk("redirect", {15'h0, redirect}, {15'h0, m_redirect});
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("mode_set", {14'h0, mode_set}, {14'h0, m_mode_set});
    chk("epc", epc, m_epc);
    chk("cause", {13'h0, cause}, 16'(m_cause));
    chk("drain_tmo", {15'h0, drain_tmo}, {15'h0, m_tmo});
    if (redirect) redir_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic quiet();
    bad_instr = 0; illegal_pc = 0; illegal_mem = 0; spart_rcv = 0; eret = 0;
  endtask

  initial begin : stim
    int r0;
    rst = 1'b1; quiet(); mode = 2'b00; cur_pc = 16'h0; pipe_idle = 1'b1;
    steps(3);
    @(negedge clk);
    chk("reset_redirect", {15'h0, redirect}, 16'h0);
    chk("reset_cause", {13'h0, cause}, 16'h0);
    step(); rst = 1'b0;
    steps(2);

    // 1: illegal_mem, pipe already idle
    illegal_mem = 1; cur_pc = 16'h1234;          // t
    step(); illegal_mem = 0; cur_pc = 16'h2222;  // t+1: epc source
    step(); cur_pc = 16'h3333;                   // t+2
    step();                                      // t+3
    @(negedge clk);
    chk("t1_redirect", {15'h0, redirect}, 16'h1);
    chk("t1_vector", redirect_pc, 16'h0100);
    chk("t1_cause", {13'h0, cause}, 16'h3);
    chk("t1_epc", epc, 16'h2222);
    step(); eret = 1;
    step(); eret = 0;
    @(negedge clk);
    chk("t1_ret_pc", redirect_pc, 16'h2222);
    chk("t1_ret_mode", {14'h0, mode_set}, 16'h3);
    step();
    @(negedge clk);
    chk("t1_cause_cleared", {13'h0, cause}, 16'h0);
    steps(2);

    // 2: spart + bad_instr together; spart first, bad_instr back-to-back after return
    spart_rcv = 1; bad_instr = 1; cur_pc = 16'h4000;   // t
    step(); quiet(); cur_pc = 16'h4100;                // t+1
    steps(2);                                          // t+3
    @(negedge clk);
    chk("t2_vector_spart", redirect_pc, 16'h0030);
    chk("t2_cause_spart", {13'h0, cause}, 16'h1);
    chk("t2_epc", epc, 16'h4100);
    steps(2); eret = 1; cur_pc = 16'h5000;             // t+5
    step(); eret = 0;                                  // t+6 return
    @(negedge clk);
    chk("t2_ret_redirect", {15'h0, redirect}, 16'h1);
    chk("t2_ret_pc", redirect_pc, 16'h4100);
    chk("t2_ret_mode", {14'h0, mode_set}, 16'h3);
    step(); cur_pc = 16'h5555;                         // t+7 idle takes bad_instr
    steps(2);                                          // t+9
    @(negedge clk);
    chk("t2_vector_badi", redirect_pc, 16'h0060);
    chk("t2_cause_badi", {13'h0, cause}, 16'h4);
    chk("t2_epc_badi", epc, 16'h5555);
    step(); eret = 1;
    step(); eret = 0;
    steps(2);

    // 3: spart masked while privileged
    mode = 2'b10; r0 = redir_cnt;
    spart_rcv = 1;
    step(); spart_rcv = 0;
    steps(20);
    @(negedge clk);
    chk("t3_no_redirect", 16'(redir_cnt - r0), 16'h0);
    mode = 2'b00;

    // 4: drain timeout
    pipe_idle = 0; illegal_pc = 1; cur_pc = 16'h0700;  // t
    step(); illegal_pc = 0;                            // t+1
    steps(1 + DRAIN_MAX - 1);                          // t+9
    @(negedge clk);
    chk("t4_not_early", {15'h0, redirect}, 16'h0);
    step();                                            // t+10
    @(negedge clk);
    chk("t4_redirect", {15'h0, redirect}, 16'h1);
    chk("t4_vector", redirect_pc, 16'hffff & 16'h0000);
    chk("t4_cause", {13'h0, cause}, 16'h2);
    chk("t4_tmo", {15'h0, drain_tmo}, 16'h1);
    pipe_idle = 1;
    step(); eret = 1;
    step(); eret = 0;
    steps(3);
    @(negedge clk);
    chk("t4_tmo_sticky", {15'h0, drain_tmo}, 16'h1);

    // 5: eret while idle is ignored
    r0 = redir_cnt;
    eret = 1;
    step(); eret = 0;
    steps(5);
    @(negedge clk);
    chk("t5_idle_eret", 16'(redir_cnt - r0), 16'h0);

    // 6: reset in DRAIN with two causes pending
    pipe_idle = 0; illegal_mem = 1; bad_instr = 1; cur_pc = 16'h0abc;
    step(); quiet();
    steps(2);                                           // DRAIN
    rst = 1'b1;
    #1;
    chk("t6_rst_redirect", {15'h0, redirect}, 16'h0);
    chk("t6_rst_epc", epc, 16'h0);
    chk("t6_rst_cause", {13'h0, cause}, 16'h0);
    chk("t6_rst_tmo", {15'h0, drain_tmo}, 16'h0);
    step(); rst = 1'b0; pipe_idle = 1; r0 = redir_cnt;
    steps(15);
    @(negedge clk);
    chk("t6_no_redirect", 16'(redir_cnt - r0), 16'h0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      rst         = ($urandom_range(0, 399) == 0);
      spart_rcv   = ($urandom_range(0, 11) == 0);
      illegal_pc  = ($urandom_range(0, 11) == 0);
      illegal_mem = ($urandom_range(0, 11) == 0);
      bad_instr   = ($urandom_range(0, 11) == 0);
      eret        = ($urandom_range(0, 4) == 0);
      pipe_idle   = ($urandom_range(0, 2) != 0);
      mode        = 2'($urandom_range(0, 3));
      cur_pc      = 16'($urandom);
    end
    step(); rst = 1'b0; quiet();
    steps(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
